rmii_dibit_assembler: RTL and testbench

Receive-side counterpart to the transmit byte-to-dibit buffer. Takes the 2-bit RMII-style dibit stream (valid-qualified, LSB dibit first) and strips the preamble/SFD. It reassembles payload bytes and emits one byte-valid pulse per byte, plus frame-boundary and error flags. It sits between the PHY-facing input register stage and the downstream packet parser or checksum logic.

---
 rtl/rmii_dibit_assembler.sv | 141 ++++++++++++++
 tb/tb_rmii_dibit_assembler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_dibit_assembler.sv
// rmii_dibit_assembler: strips preamble/SFD from a valid-qualified RMII dibit
// stream (LSB dibit first), reassembles payload bytes and flags frame bounds.
module rmii_dibit_assembler #(
   parameter int unsigned MIN_PREAMBLE = 8,
   parameter int unsigned MAX_BYTES    = 1522
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   output logic        axiov,
   output logic [7:0]  axiod,
   output logic        frame_start,
   output logic        frame_done,
   output logic        frame_err,
   output logic [10:0] byte_count
);

   localparam int unsigned PRE_W   = 6;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned SHIFT_W = 6;
   localparam int unsigned BC_W    = 11;

   localparam logic [PRE_W-1:0] PRE_SAT    = '1;
   localparam logic [BC_W-1:0]  BC_SAT     = '1;
   localparam logic [1:0]       DIBIT_PRE  = 2'b01;
   localparam logic [1:0]       DIBIT_SFD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      DROP     = 2'd3
   } state_t;

   state_t               state;
   logic [PRE_W-1:0]     pre_cnt;
   logic [IDX_W-1:0]     idx;
   logic [SHIFT_W-1:0]   shift;
   logic                 sticky_err;
   logic                 in_frame;

   // Frame FSM, byte assembly and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pre_cnt     <= '0;
         idx         <= '0;
         shift       <= '0;
         sticky_err  <= 1'b0;
         in_frame    <= 1'b0;
         axiov       <= 1'b0;
         axiod       <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         byte_count  <= '0;
      end else begin
         axiov       <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (axiiv) begin
                  if (axiid == DIBIT_PRE) begin
                     state   <= PREAMBLE;
                     pre_cnt <= PRE_W'(1);
                  end else begin
                     state <= DROP;
                  end
               end
            end

            PREAMBLE: begin
               if (!axiiv) begin
                  // carrier lost before SFD: nothing was started, nothing to report
                  state <= IDLE;
               end else if (axiid == DIBIT_PRE) begin
                  if (pre_cnt != PRE_SAT) begin
                     pre_cnt <= pre_cnt + PRE_W'(1);
                  end
               end else if ((axiid == DIBIT_SFD) && (32'(pre_cnt) >= MIN_PREAMBLE)) begin
                  state       <= DATA;
                  frame_start <= 1'b1;
                  byte_count  <= '0;
                  idx         <= '0;
                  sticky_err  <= 1'b0;
                  in_frame    <= 1'b1;
               end else begin
                  state <= DROP;
               end
            end

            DATA: begin
               if (!axiiv) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
                  frame_err  <= (idx != '0) | sticky_err;
                  in_frame   <= 1'b0;
                  idx        <= '0;
               end else begin
                  idx <= idx + IDX_W'(1);
                  case (idx)
                     2'd0: shift[1:0] <= axiid;
                     2'd1: shift[3:2] <= axiid;
                     2'd2: shift[5:4] <= axiid;
                     default: begin
                        // 4th dibit completes the byte unless it would overrun the limit
                        if (32'(byte_count) >= MAX_BYTES) begin
                           sticky_err <= 1'b1;
                           state      <= DROP;
                        end else begin
                           axiod <= {axiid, shift};
                           axiov <= 1'b1;
                           if (byte_count != BC_SAT) begin
                              byte_count <= byte_count + BC_W'(1);
                           end
                        end
                     end
                  endcase
               end
            end

            DROP: begin
               if (!axiiv) begin
                  // only frames that reached payload get a (failed) completion
                  state      <= IDLE;
                  frame_done <= in_frame;
                  frame_err  <= in_frame;
                  in_frame   <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rmii_dibit_assembler.sv
// tb_rmii_dibit_assembler: directed and random frames against a frame-level model.
module tb_rmii_dibit_assembler;

   localparam int MIN_PRE = 8;
   localparam int MAX_B   = 4;
   localparam int NMAX    = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        axiiv;
   logic [1:0]  axiid;
   logic        axiov;
   logic [7:0]  axiod;
   logic        frame_start;
   logic        frame_done;
   logic        frame_err;
   logic [10:0] byte_count;

   rmii_dibit_assembler #(.MIN_PREAMBLE(MIN_PRE), .MAX_BYTES(MAX_B)) dut (
      .clk         (clk),
      .rst         (rst),
      .axiiv       (axiiv),
      .axiid       (axiid),
      .axiov       (axiov),
      .axiod       (axiod),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .byte_count  (byte_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // stimulus for the current segment, one entry per clock
   bit         sv_q[$];
   logic [1:0] sd_q[$];

   // expected outputs after the edge that samples stimulus entry k
   bit          e_v  [NMAX];
   bit          e_fs [NMAX];
   bit          e_fd [NMAX];
   bit          e_fe [NMAX];
   logic [7:0]  e_byte [NMAX];
   logic [7:0]  e_d  [NMAX];
   logic [10:0] e_bc [NMAX];
   logic [7:0]  m_d;
   logic [10:0] m_bc;

   // observed DUT events, used to pin the model with literal expectations
   int         obs_v, obs_fs, obs_fd, obs_fe;
   logic [7:0] obs_b[$];

   bit chk_en = 1'b0;
   int cur    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_b(input int i);
      if (obs_b.size() > i) return obs_b[i];
      return 8'hxx;
   endfunction

   task automatic clear_obs();
      obs_v = 0; obs_fs = 0; obs_fd = 0; obs_fe = 0;
      obs_b.delete();
   endtask

   task automatic push(input bit v, input logic [1:0] d);
      sv_q.push_back(v);
      sd_q.push_back(d);
   endtask

   task automatic push_pre(input int n);
      repeat (n) push(1'b1, 2'b01);
   endtask

   task automatic push_byte(input logic [7:0] b);
      push(1'b1, b[1:0]);
      push(1'b1, b[3:2]);
      push(1'b1, b[5:4]);
      push(1'b1, b[7:6]);
   endtask

   task automatic push_idle(input int n);
      repeat (n) push(1'b0, 2'b00);
   endtask

   // Frame-level model: split the stream into carrier bursts and decode each one.
   task automatic build_model();
      int n, k, b, e, r, m, nb, rem, em, p;
      logic [7:0] bv;
      n = sv_q.size();
      for (int i = 0; i < n; i++) begin
         e_v[i] = 0; e_fs[i] = 0; e_fd[i] = 0; e_fe[i] = 0; e_byte[i] = 8'h00;
      end
      k = 0;
      while (k < n) begin
         if (!sv_q[k]) begin
            k++;
         end else begin
            b = k;
            e = k;
            while (e < n && sv_q[e]) e++;
            r = 0;
            while (b + r < e && sd_q[b + r] == 2'b01) r++;
            if (r > 0 && b + r < e && sd_q[b + r] == 2'b11 && r >= MIN_PRE) begin
               e_fs[b + r] = 1;
               m   = e - (b + r + 1);
               nb  = m / 4;
               rem = m % 4;
               em  = (nb < MAX_B) ? nb : MAX_B;
               for (int j = 0; j < em; j++) begin
                  p  = b + r + 1 + 4 * j;
                  bv = {sd_q[p + 3], sd_q[p + 2], sd_q[p + 1], sd_q[p]};
                  e_v[p + 3]    = 1;
                  e_byte[p + 3] = bv;
               end
               if (e < n) begin
                  e_fd[e] = 1;
                  e_fe[e] = (nb > MAX_B) || (rem != 0);
               end
            end
            k = e;
         end
      end
      for (int i = 0; i < n; i++) begin
         if (e_fs[i]) m_bc = 11'd0;
         if (e_v[i]) begin
            m_bc = m_bc + 11'd1;
            m_d  = e_byte[i];
         end
         e_bc[i] = m_bc;
         e_d[i]  = m_d;
      end
   endtask

   task automatic compare(input int k);
      chk("axiov",       32'(axiov),       32'(e_v[k]));
      chk("frame_start", 32'(frame_start), 32'(e_fs[k]));
      chk("frame_done",  32'(frame_done),  32'(e_fd[k]));
      chk("axiod",       32'(axiod),       32'(e_d[k]));
      chk("byte_count",  32'(byte_count),  32'(e_bc[k]));
      if (e_fd[k]) chk("frame_err", 32'(frame_err), 32'(e_fe[k]));
      if (axiov) begin
         obs_v++;
         obs_b.push_back(axiod);
      end
      if (frame_start) obs_fs++;
      if (frame_done) begin
         obs_fd++;
         if (frame_err) obs_fe++;
      end
   endtask

   // Single compare process: checks every sampled cycle of a segment.
   always @(posedge clk) begin
      if (chk_en) begin
         #1;
         compare(cur);
      end
   end

   task automatic run_seg();
      int n;
      build_model();
      n = sv_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         axiiv  = sv_q[k];
         axiid  = sd_q[k];
         cur    = k;
         chk_en = 1'b1;
      end
      @(negedge clk);
      chk_en = 1'b0;
      sv_q.delete();
      sd_q.delete();
   endtask

   task automatic push_rand_frame();
      logic [1:0] d;
      if ($urandom_range(0, 7) == 0) begin
         d = 2'($urandom_range(0, 3));
         if (d == 2'b01) d = 2'b00;
         push(1'b1, d);
      end
      push_pre(int'($urandom_range(1, 14)));
      d = 2'b11;
      if ($urandom_range(0, 5) == 0) d = 2'($urandom_range(0, 3));
      push(1'b1, d);
      repeat (int'($urandom_range(0, 28))) push(1'b1, 2'($urandom_range(0, 3)));
      push_idle(int'($urandom_range(1, 3)));
   endtask

   initial begin
      rst   = 1'b0;
      axiiv = 1'b0;
      axiid = 2'b00;
      m_d   = 8'h00;
      m_bc  = 11'd0;
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_axiov",       32'(axiov),       32'd0);
      chk("reset_axiod",       32'(axiod),       32'd0);
      chk("reset_frame_start", 32'(frame_start), 32'd0);
      chk("reset_frame_done",  32'(frame_done),  32'd0);
      chk("reset_frame_err",   32'(frame_err),   32'd0);
      chk("reset_byte_count",  32'(byte_count),  32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 7 bytes of 01010101 preamble, SFD byte ending in 11, payload D2 3C
      clear_obs();
      push_idle(1);
      push_pre(28);
      push_pre(3);
      push(1'b1, 2'b11);
      push_byte(8'hD2);
      push_byte(8'h3C);
      push_idle(2);
      run_seg();
      chk("t1_starts", 32'(obs_fs), 32'd1);
      chk("t1_bytes",  32'(obs_v),  32'd2);
      chk("t1_byte0",  32'(get_b(0)), 32'hD2);
      chk("t1_byte1",  32'(get_b(1)), 32'h3C);
      chk("t1_count",  32'(byte_count), 32'd2);
      chk("t1_done",   32'(obs_fd), 32'd1);
      chk("t1_errs",   32'(obs_fe), 32'd0);

      // short preamble is dropped silently, then a good frame still decodes
      clear_obs();
      push_pre(4);
      push(1'b1, 2'b11);
      push_byte(8'h77);
      push_idle(1);
      push_pre(8);
      push(1'b1, 2'b11);
      push_byte(8'h5A);
      push_idle(2);
      run_seg();
      chk("t2_starts", 32'(obs_fs), 32'd1);
      chk("t2_bytes",  32'(obs_v),  32'd1);
      chk("t2_byte0",  32'(get_b(0)), 32'h5A);
      chk("t2_done",   32'(obs_fd), 32'd1);

      // one full byte then a partial byte
      clear_obs();
      push_pre(10);
      push(1'b1, 2'b11);
      push_byte(8'hA5);
      push(1'b1, 2'b10);
      push(1'b1, 2'b01);
      push_idle(2);
      run_seg();
      chk("t3_bytes", 32'(obs_v), 32'd1);
      chk("t3_byte0", 32'(get_b(0)), 32'hA5);
      chk("t3_done",  32'(obs_fd), 32'd1);
      chk("t3_err",   32'(obs_fe), 32'd1);
      chk("t3_count", 32'(byte_count), 32'd1);

      // overlength: six bytes offered with a four-byte limit
      clear_obs();
      push_pre(8);
      push(1'b1, 2'b11);
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
      push_idle(2);
      run_seg();
      chk("t4_bytes", 32'(obs_v), 32'd4);
      chk("t4_last",  32'(get_b(3)), 32'h44);
      chk("t4_done",  32'(obs_fd), 32'd1);
      chk("t4_err",   32'(obs_fe), 32'd1);
      chk("t4_count", 32'(byte_count), 32'd4);

      // reset two dibits into the payload
      clear_obs();
      push_pre(8);
      push(1'b1, 2'b11);
      push(1'b1, 2'b10);
      push(1'b1, 2'b11);
      run_seg();
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_axiov",       32'(axiov),       32'd0);
      chk("mid_rst_axiod",       32'(axiod),       32'd0);
      chk("mid_rst_frame_start", 32'(frame_start), 32'd0);
      chk("mid_rst_frame_done",  32'(frame_done),  32'd0);
      chk("mid_rst_frame_err",   32'(frame_err),   32'd0);
      chk("mid_rst_byte_count",  32'(byte_count),  32'd0);
      axiiv = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      m_d  = 8'h00;
      m_bc = 11'd0;
      clear_obs();
      push_idle(2);
      push_pre(9);
      push(1'b1, 2'b11);
      push_byte(8'hC3);
      push_byte(8'h96);
      push_idle(2);
      run_seg();
      chk("t5_bytes", 32'(obs_v), 32'd2);
      chk("t5_byte1", 32'(get_b(1)), 32'h96);
      chk("t5_done",  32'(obs_fd), 32'd1);

      // back-to-back frames with a single idle cycle between them
      clear_obs();
      push_pre(8);
      push(1'b1, 2'b11);
      push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE);
      push_idle(1);
      push_pre(8);
      push(1'b1, 2'b11);
      push_byte(8'hEF);
      push_idle(2);
      run_seg();
      chk("t6_starts", 32'(obs_fs), 32'd2);
      chk("t6_bytes",  32'(obs_v),  32'd4);
      chk("t6_byte3",  32'(get_b(3)), 32'hEF);
      chk("t6_done",   32'(obs_fd), 32'd2);
      chk("t6_errs",   32'(obs_fe), 32'd0);
      chk("t6_count",  32'(byte_count), 32'd1);

      // random frames: good, short preamble, bad SFD, garbage start, partial, overlength
      for (int s = 0; s < 8; s++) begin
         repeat (5) push_rand_frame();
         run_seg();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
